addsub_seq_ctrl: RTL and testbench

Sequential add/subtract controller for the ALU AddSub path. It time-shares a single 4-bit carry-lookahead slice across the operand width, one nibble per cycle, carrying the slice carry-out between beats. Operands come in and results go out over valid/ready handshakes. It serves as the area-reduced alternative to the fully parallel 32-bit adder and sits between the ALU operand registers and the ALU result mux.

---
 rtl/addsub_seq_pkg.sv | 20 ++
 rtl/addsub_seq_ctrl_cla4_slice.sv | 34 +++
 rtl/addsub_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addsub_seq_pkg: shared FSM state type and slice geometry for addsub_seq_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seq_ctrl_cla4_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla4_slice: combinational 4-bit carry-lookahead adder slice. Rev 1.0
// ---------------------------------------------------------------------------
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms keep every carry two logic levels from cin.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule
`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addsub_seq_ctrl: nibble-serial add/sub over one CLA slice; ADDSUB_SEQ_FLAGS_EN enables ovf/zero. Rev 1.0
// ---------------------------------------------------------------------------
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = $clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [IDXW+1:0]  bit_base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             s_c3;
  logic             s_cout;

  assign bit_base = {idx, 2'b00};
  assign a_nib    = a_q[bit_base +: SLICE_W];
  assign b_nib    = b_q[bit_base +: SLICE_W];

  cla4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .c3   (s_c3),
    .cout (s_cout)
  );

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic zacc;
  logic ovf_q;
  logic zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zacc   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        zacc   <= 1'b0;
        ovf_q  <= 1'b0;
        zero_q <= 1'b0;
      end else if (state == RUN) begin
        zacc <= zacc | (|s_nib);
        if (idx == LAST_IDX) begin
          ovf_q  <= s_c3 ^ s_cout;
          zero_q <= ~(zacc | (|s_nib));
        end
      end
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  logic unused_c3;
  assign unused_c3 = s_c3;
  assign ovf       = 1'b0;
  assign zero      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry      <= sub;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[bit_base +: SLICE_W] <= s_nib;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_q      <= s_cout;
            idx         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_addsub_seq_ctrl: directed vectors with a queue-based result scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
module tb_addsub_seq_ctrl;

`ifdef ADDSUB_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];

  addsub_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected result for every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(sum), 64'hDEAD);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sum",  64'(sum),  64'(e.sum));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf",  64'(ovf),  64'(e.ovf));
        chk("zero", 64'(zero), 64'(e.zero));
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    sb.push_back('{sum: es, cout: ec, ovf: eo & FLAGS, zero: ez & FLAGS});
    issue(av, bv, sv);
    wait_result(8);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_cout",      64'(cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op(32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold while inputs wiggle.
    out_ready = 1'b0;
    sb.push_back('{sum: 32'h2345_6789, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_result(8);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 32'hA5A5_0000 + 32'(i);
      b = 32'h0F0F_0000 + 32'(i);
      sub = i[0];
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_sum",       64'(sum),       64'h2345_6789);
      chk("bp_cout",      64'(cout),      64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready",  64'(in_ready),  64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy",      64'(busy),      64'd0);
    sb.push_back('{sum: 32'h0000_0009, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    issue(32'h0000_0004, 32'h0000_0005, 1'b0);
    chk("bp_next_accept_busy", 64'(busy), 64'd1);
    wait_result(8);
    @(posedge clk); #1;

    // Reset asserted so it is sampled on the edge of RUN beat 3.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    chk("mid_rst_sum",       64'(sum),       64'd0);
    chk("mid_rst_cout",      64'(cout),      64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
